// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline front-end control blocks.
package mips_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/if_id_stall_ctrl_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {WIDTH{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID stall/flush control: gates PC write, holds or flushes IF/ID, selects the
// ID/EX control bubble, and tracks stall/flush statistics and protocol errors.
//
// state    | meaning
// ST_RUN   | pipe advancing normally
// ST_STALL | previous cycle was a stall (IF/ID held)
// ST_FLUSH | previous cycle flushed IF/ID after a taken branch
module if_id_stall_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(mips_pipe_pkg::NOP_INSTR),
    parameter int               CNT_W     = mips_pipe_pkg::CNT_W_DEF,
    parameter int               MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  instr_if,
    input  logic [XLEN-1:0]  pc4_if,
    input  logic             hdu_write,
    input  logic             hdu_noop,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic [XLEN-1:0]  instr_id,
    output logic [XLEN-1:0]  pc4_id,
    output logic             id_valid,
    output logic             ctrl_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             proto_err,
    output logic             hang_err
);

    localparam int RL_W = $clog2(MAX_STALL + 2);

    pipe_state_t     state_q, state_d;
    logic            stall, flush;
    logic            pair_bad;
    logic [RL_W-1:0] run_len;

    // A mismatched request pair is treated as a stall so the pipe never advances on bad data.
    assign stall       = ~hdu_write | hdu_noop;
    assign flush       = branch_taken & ~stall;
    assign pair_bad    = (hdu_write == hdu_noop);
    assign pc_write    = ~stall;
    assign ctrl_bubble = stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN, ST_STALL, ST_FLUSH: begin
                if (stall) begin
                    state_d = ST_STALL;
                end else if (flush) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_id <= NOP_INSTR;
            pc4_id   <= '0;
            id_valid <= 1'b0;
        end else if (stall) begin
            instr_id <= instr_id;
            pc4_id   <= pc4_id;
            id_valid <= id_valid;
        end else if (flush) begin
            instr_id <= NOP_INSTR;
            pc4_id   <= '0;
            id_valid <= 1'b0;
        end else begin
            instr_id <= instr_if;
            pc4_id   <= pc4_if;
            id_valid <= 1'b1;
        end
    end

    // run_len counts stall cycles already completed in the current run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len <= '0;
        end else if (stall) begin
            if (run_len < RL_W'(MAX_STALL + 1)) begin
                run_len <= run_len + 1'b1;
            end
        end else begin
            run_len <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
            hang_err  <= 1'b0;
        end else begin
            if (pair_bad) begin
                proto_err <= 1'b1;
            end
            if (stall && (run_len >= RL_W'(MAX_STALL))) begin
                hang_err <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall),
        .q   (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Directed bench for if_id_stall_ctrl with a behavioural model checked every cycle.
module tb_if_id_stall_ctrl;

    localparam int MAX_STALL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_if, pc4_if;
    logic        hdu_write, hdu_noop, branch_taken;

    logic        pc_write, id_valid, ctrl_bubble, proto_err, hang_err;
    logic [31:0] instr_id, pc4_id;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_id_valid, s_ctrl_bubble, s_proto_err, s_hang_err;
    logic [31:0] s_instr_id, s_pc4_id;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad   = 0;

    // model state
    logic [31:0] m_instr, m_pc4;
    logic        m_valid, m_proto, m_hang;
    int          m_nstall, m_nflush, m_consec;

    always #5 clk = ~clk;

    if_id_stall_ctrl #(.XLEN(32), .CNT_W(16), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst(rst), .instr_if(instr_if), .pc4_if(pc4_if),
        .hdu_write(hdu_write), .hdu_noop(hdu_noop), .branch_taken(branch_taken),
        .pc_write(pc_write), .instr_id(instr_id), .pc4_id(pc4_id), .id_valid(id_valid),
        .ctrl_bubble(ctrl_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .proto_err(proto_err), .hang_err(hang_err)
    );

    if_id_stall_ctrl #(.XLEN(32), .CNT_W(2), .MAX_STALL(MAX_STALL)) dut_small (
        .clk(clk), .rst(rst), .instr_if(instr_if), .pc4_if(pc4_if),
        .hdu_write(hdu_write), .hdu_noop(hdu_noop), .branch_taken(branch_taken),
        .pc_write(s_pc_write), .instr_id(s_instr_id), .pc4_id(s_pc4_id), .id_valid(s_id_valid),
        .ctrl_bubble(s_ctrl_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
        .proto_err(s_proto_err), .hang_err(s_hang_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int n, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (n > lim) ? 64'(lim) : 64'(n);
    endfunction

    // Model: a cycle stalls unless the hazard unit gives exactly Write=1, NoOp=0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
            m_proto <= 1'b0;  m_hang <= 1'b0;
            m_nstall <= 0; m_nflush <= 0; m_consec <= 0;
        end else begin
            if (hdu_write == hdu_noop) m_proto <= 1'b1;
            if (!(hdu_write && !hdu_noop)) begin
                m_nstall <= m_nstall + 1;
                m_consec <= m_consec + 1;
                if (m_consec + 1 > MAX_STALL) m_hang <= 1'b1;
            end else begin
                m_consec <= 0;
                if (branch_taken) begin
                    m_nflush <= m_nflush + 1;
                    m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
                end else begin
                    m_instr <= instr_if; m_pc4 <= pc4_if; m_valid <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = !(hdu_write && !hdu_noop);
        chk("pc_write",    64'(pc_write),    64'(!exp_stall));
        chk("ctrl_bubble", 64'(ctrl_bubble), 64'(exp_stall));
        chk("instr_id",    64'(instr_id),    64'(m_instr));
        chk("pc4_id",      64'(pc4_id),      64'(m_pc4));
        chk("id_valid",    64'(id_valid),    64'(m_valid));
        chk("stall_cnt",   64'(stall_cnt),   sat(m_nstall, 16));
        chk("flush_cnt",   64'(flush_cnt),   sat(m_nflush, 16));
        chk("proto_err",   64'(proto_err),   64'(m_proto));
        chk("hang_err",    64'(hang_err),    64'(m_hang));
        chk("s_pc_write",  64'(s_pc_write),  64'(!exp_stall));
        chk("s_bubble",    64'(s_ctrl_bubble), 64'(exp_stall));
        chk("s_instr_id",  64'(s_instr_id),  64'(m_instr));
        chk("s_pc4_id",    64'(s_pc4_id),    64'(m_pc4));
        chk("s_id_valid",  64'(s_id_valid),  64'(m_valid));
        chk("s_stall_cnt", 64'(s_stall_cnt), sat(m_nstall, 2));
        chk("s_flush_cnt", 64'(s_flush_cnt), sat(m_nflush, 2));
        chk("s_proto_err", 64'(s_proto_err), 64'(m_proto));
        chk("s_hang_err",  64'(s_hang_err),  64'(m_hang));
    end

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic w, input logic n, input logic b);
        instr_if = i; pc4_if = p; hdu_write = w; hdu_noop = n; branch_taken = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h8C22_0004, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
        #3;
        chk("rst_instr", 64'(instr_id), 64'h0);
        chk("rst_valid", 64'(id_valid), 64'h0);
        chk("rst_scnt",  64'(stall_cnt), 64'h0);
        #4;
        rst = 1'b0;

        // 1: clean fetch
        tick();
        chk("t1_instr", 64'(instr_id), 64'h8C22_0004);
        chk("t1_valid", 64'(id_valid), 64'h1);
        chk("t1_pcw",   64'(pc_write), 64'h1);
        chk("t1_bub",   64'(ctrl_bubble), 64'h0);

        // 2: load-use stall for one cycle
        drive(32'h0043_0820, 32'h0000_0008, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t2_pcw", 64'(pc_write), 64'h0);
        chk("t2_bub", 64'(ctrl_bubble), 64'h1);
        tick();
        chk("t2_hold", 64'(instr_id), 64'h8C22_0004);
        chk("t2_scnt", 64'(stall_cnt), 64'h1);
        drive(32'h0043_0820, 32'h0000_0008, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t2_load", 64'(instr_id), 64'h0043_0820);

        // 3: taken branch flush, then refill
        drive(32'h1111_1111, 32'h0000_000C, 1'b1, 1'b0, 1'b1);
        tick();
        chk("t3_instr", 64'(instr_id), 64'h0);
        chk("t3_pc4",   64'(pc4_id), 64'h0);
        chk("t3_valid", 64'(id_valid), 64'h0);
        chk("t3_fcnt",  64'(flush_cnt), 64'h1);
        drive(32'h2222_2222, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t3_refill", 64'(instr_id), 64'h2222_2222);
        chk("t3_rvalid", 64'(id_valid), 64'h1);

        // 4: branch under stall is ignored until the stall clears
        pulse_rst();
        drive(32'h3333_3333, 32'h0000_0014, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        chk("t4_nofl", 64'(flush_cnt), 64'h0);
        chk("t4_scnt", 64'(stall_cnt), 64'h2);
        drive(32'h3333_3333, 32'h0000_0014, 1'b1, 1'b0, 1'b1);
        tick();
        chk("t4_fcnt",  64'(flush_cnt), 64'h1);
        chk("t4_scnt2", 64'(stall_cnt), 64'h2);
        chk("t4_valid", 64'(id_valid), 64'h0);

        // 5: hang after MAX_STALL+1 stall cycles, then a bad pair
        pulse_rst();
        drive(32'h4444_4444, 32'h0000_0018, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < MAX_STALL; k++) tick();
        chk("t5_nohang", 64'(hang_err), 64'h0);
        tick();
        chk("t5_hang",  64'(hang_err), 64'h1);
        chk("t5_small", 64'(s_stall_cnt), 64'h3);
        drive(32'h4444_4444, 32'h0000_0018, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t5_bad_pcw", 64'(pc_write), 64'h0);
        tick();
        chk("t5_proto", 64'(proto_err), 64'h1);
        chk("t5_scnt",  64'(stall_cnt), 64'h6);
        drive(32'h5555_5555, 32'h0000_001C, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("t5_sticky", 64'(hang_err), 64'h1);
        chk("t5_psticky", 64'(proto_err), 64'h1);

        // 6: narrow counter saturates, then async reset mid-stall
        drive(32'h6666_6666, 32'h0000_0020, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        chk("t6_sat", 64'(s_stall_cnt), 64'h3);
        rst = 1'b1;
        #1;
        chk("t6_rinstr", 64'(instr_id), 64'h0);
        chk("t6_rvalid", 64'(id_valid), 64'h0);
        chk("t6_rscnt",  64'(s_stall_cnt), 64'h0);
        chk("t6_rhang",  64'(hang_err), 64'h0);
        chk("t6_rproto", 64'(proto_err), 64'h0);
        chk("t6_rpcw",   64'(pc_write), 64'h0);
        rst = 1'b0;
        drive(32'h7777_7777, 32'h0000_0024, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t6_after", 64'(instr_id), 64'h7777_7777);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
